// File: rtl/control_unit_mc_pkg.sv
// Shared types, opcodes and decode helpers for the multicycle ALU control unit.
package control_unit_mc_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F7_W  = 7;
  localparam int unsigned F3_W  = 3;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // ALU/MDU operation codes
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1010;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b1011;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b1100;

  localparam logic [OPC_W-1:0] R_OPCODE = 7'b0110011;
  localparam logic [F7_W-1:0]  F7_BASE  = 7'b0000000;
  localparam logic [F7_W-1:0]  F7_ALT   = 7'b0100000;
  localparam logic [F7_W-1:0]  F7_MD    = 7'b0000001;

  // Decoder result
  typedef struct packed {
    logic [OP_W-1:0] code;
    logic            mc;
    logic            illegal;
  } dec_t;

  // Base R-type map for funct7 == 0
  function automatic logic [OP_W-1:0] base_code(input logic [F3_W-1:0] func);
    logic [OP_W-1:0] code;
    case (func)
      3'b000:  code = OP_ADD;
      3'b001:  code = OP_SLL;
      3'b010:  code = OP_SLT;
      3'b011:  code = OP_SLTU;
      3'b100:  code = OP_XOR;
      3'b101:  code = OP_SRL;
      3'b110:  code = OP_OR;
      default: code = OP_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// Fetch/execute handshake bundle for control_unit_mc.
interface control_unit_mc_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [XLEN-1:0]   instr;
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [CTRL_W-1:0] ctrl_sig;
  logic              ctrl_mc;
  logic              exec_done;
  logic              wb_en;
  logic              illegal_instr;
  logic              timeout_err;
  logic [CNT_W-1:0]  retire_cnt;
  logic              busy;

  // Fetch / execute side
  modport master (
    output instr_valid, instr, ctrl_ready, exec_done,
    input  instr_ready, ctrl_valid, ctrl_sig, ctrl_mc, wb_en,
           illegal_instr, timeout_err, retire_cnt, busy
  );

  // Control unit side
  modport slave (
    input  instr_valid, instr, ctrl_ready, exec_done,
    output instr_ready, ctrl_valid, ctrl_sig, ctrl_mc, wb_en,
           illegal_instr, timeout_err, retire_cnt, busy
  );
endinterface

// File: rtl/control_unit_mc_decode.sv
// Combinational R-type decoder: instruction fields -> op code, multicycle flag, illegal flag.
module control_unit_mc_decode
  import control_unit_mc_pkg::*;
#(
  parameter bit MULDIV_EN     = 1'b1,
  parameter bit STRICT_DECODE = 1'b0
) (
  input  logic [31:0] instr,
  output dec_t        dec_c
);

  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  func;
  logic [F7_W-1:0]  funct7;
  logic             unused_fields;

  assign opcode        = instr[6:0];
  assign func          = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Field decode; strict mode rejects anything outside the known R-type space
  always_comb begin
    dec_c = '0;
    if (STRICT_DECODE && (opcode != R_OPCODE)) begin
      dec_c.illegal = 1'b1;
    end else if (funct7 == F7_BASE) begin
      dec_c.code = base_code(func);
    end else if (MULDIV_EN && (funct7 == F7_MD)) begin
      dec_c.code = func[2] ? OP_DIV : OP_MUL;
      dec_c.mc   = 1'b1;
    end else if (!STRICT_DECODE) begin
      dec_c.code = (func == 3'b000) ? OP_SUB : OP_SRA;
    end else if ((funct7 == F7_ALT) && ((func == 3'b000) || (func == 3'b101))) begin
      dec_c.code = (func == 3'b000) ? OP_SUB : OP_SRA;
    end else begin
      dec_c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle ALU control unit: accepts R-type instrs, decodes, issues, waits on MDU, retires.
module control_unit_mc
  import control_unit_mc_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned CTRL_W        = 4,
  parameter bit          MULDIV_EN     = 1'b1,
  parameter bit          STRICT_DECODE = 1'b0,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned CNT_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  control_unit_mc_if.slave  bus
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [CTRL_W-1:0] ctrl_sig_q, ctrl_sig_d;
  logic              ctrl_mc_q, ctrl_mc_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic              instr_ready_q, instr_ready_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              busy_q, busy_d;
  logic              wb_en_q, wb_en_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   instr_in;
  dec_t              dec_c;

  assign instr_in = bus.instr;

  control_unit_mc_decode #(
    .MULDIV_EN     (MULDIV_EN),
    .STRICT_DECODE (STRICT_DECODE)
  ) u_decode (
    .instr (instr_q),
    .dec_c (dec_c)
  );

  // Next-state, counters and registered-output values
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ctrl_sig_d = ctrl_sig_q;
    ctrl_mc_d  = ctrl_mc_q;
    wcnt_d     = wcnt_q;
    retire_d   = retire_q;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = instr_in[31:0];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_c.illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ctrl_sig_d = CTRL_W'(dec_c.code);
          ctrl_mc_d  = dec_c.mc;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.ctrl_ready) begin
          if (ctrl_mc_q) begin
            wcnt_d  = '0;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WAIT: begin
        // Completion on the last counted cycle still retires
        if (bus.exec_done) begin
          state_d = ST_WB;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_WB) begin
      retire_d = retire_q + CNT_W'(1);
    end

    instr_ready_d = (state_d == ST_IDLE);
    ctrl_valid_d  = (state_d == ST_ISSUE);
    busy_d        = (state_d != ST_IDLE);
    wb_en_d       = (state_d == ST_WB);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      ctrl_sig_q    <= '0;
      ctrl_mc_q     <= 1'b0;
      wcnt_q        <= '0;
      retire_q      <= '0;
      instr_ready_q <= 1'b1;
      ctrl_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      wb_en_q       <= 1'b0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      ctrl_sig_q    <= ctrl_sig_d;
      ctrl_mc_q     <= ctrl_mc_d;
      wcnt_q        <= wcnt_d;
      retire_q      <= retire_d;
      instr_ready_q <= instr_ready_d;
      ctrl_valid_q  <= ctrl_valid_d;
      busy_q        <= busy_d;
      wb_en_q       <= wb_en_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.instr_ready   = instr_ready_q;
  assign bus.ctrl_valid    = ctrl_valid_q;
  assign bus.ctrl_sig      = ctrl_sig_q;
  assign bus.ctrl_mc       = ctrl_mc_q;
  assign bus.wb_en         = wb_en_q;
  assign bus.illegal_instr = illegal_q;
  assign bus.timeout_err   = timeout_q;
  assign bus.retire_cnt    = retire_q;
  assign bus.busy          = busy_q;

endmodule
